// File: rtl/valida_rega_multi.sv
// Multi-zone irrigation validator: per-zone request debounce, minimum valve-open time,
// interlocks and latched error codes. Optional macro ERRO_AUTOLIMPA_EN enables error self-clear.
module valida_rega_multi #(
    parameter int ZONAS      = 4,
    parameter int DEB_CICLOS = 4,
    parameter int TEMPO_MIN  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ZONAS-1:0]     asp,
    input  logic [ZONAS-1:0]     got,
    input  logic [1:0]           mef1,
    input  logic                 limpeza,
    input  logic                 ve,
    input  logic                 limpa_erro,
    output logic [2*ZONAS-1:0]   rega,
    output logic [ZONAS-1:0]     erro_zona,
    output logic [2*ZONAS-1:0]   erro_cod,
    output logic                 erro
);

    localparam int DW = $clog2(DEB_CICLOS + 1);
    localparam int HW = $clog2(TEMPO_MIN + 1);
    localparam logic [DW-1:0] DEB_CARGA  = DW'(DEB_CICLOS - 1);
    localparam logic [HW-1:0] HOLD_CARGA = HW'(TEMPO_MIN - 1);

    localparam logic [2:0] OCIOSO      = 3'd0;
    localparam logic [2:0] CONFIRMA    = 3'd1;
    localparam logic [2:0] REGANDO_ASP = 3'd2;
    localparam logic [2:0] REGANDO_GOT = 3'd3;
    localparam logic [2:0] ERRO        = 3'd4;

    localparam logic [1:0] COD_ESTADO     = 2'b00;
    localparam logic [1:0] COD_SENSOR     = 2'b01;
    localparam logic [1:0] COD_ENCHIMENTO = 2'b10;
    localparam logic [1:0] COD_LIMPEZA    = 2'b11;

    // Global interlock shared by all zones.
    logic bloqueio;
    assign bloqueio = ve | limpeza | (mef1 != 2'b11);

    genvar z;
    generate
        for (z = 0; z < ZONAS; z++) begin : g_zona
            logic [2:0]    state_q, state_d;
            logic [DW-1:0] deb_q, deb_d;
            logic [HW-1:0] hold_q, hold_d;
            logic          modo_q, modo_d;
            logic [1:0]    cod_q, cod_d;
            logic          req, sensor, falha_req, mesmo;
            logic [1:0]    cod_falha;

            assign req       = asp[z] | got[z];
            assign sensor    = asp[z] & got[z];
            assign falha_req = sensor | (req & bloqueio);
            // modo_q = 1 means sprinkler; "mesmo" is true only while the stored mode alone is requested.
            assign mesmo     = modo_q ? (asp[z] & ~got[z]) : (got[z] & ~asp[z]);

            always_comb begin
                cod_falha = COD_ESTADO;
                if (sensor)       cod_falha = COD_SENSOR;
                else if (ve)      cod_falha = COD_ENCHIMENTO;
                else if (limpeza) cod_falha = COD_LIMPEZA;
            end

            always_comb begin
                state_d = state_q;
                deb_d   = deb_q;
                hold_d  = hold_q;
                modo_d  = modo_q;
                cod_d   = cod_q;
                case (state_q)
                    OCIOSO: begin
                        if (falha_req) begin
                            state_d = ERRO;
                            cod_d   = cod_falha;
                            deb_d   = DEB_CARGA;
                        end else if (asp[z] ^ got[z]) begin
                            state_d = CONFIRMA;
                            modo_d  = asp[z];
                            deb_d   = DEB_CARGA;
                        end
                    end
                    CONFIRMA: begin
                        if (falha_req) begin
                            state_d = ERRO;
                            cod_d   = cod_falha;
                            deb_d   = DEB_CARGA;
                        end else if (!mesmo) begin
                            state_d = OCIOSO;
                        end else if (deb_q != '0) begin
                            deb_d = deb_q - 1'b1;
                        end else begin
                            state_d = modo_q ? REGANDO_ASP : REGANDO_GOT;
                            hold_d  = HOLD_CARGA;
                        end
                    end
                    REGANDO_ASP, REGANDO_GOT: begin
                        if (hold_q != '0) hold_d = hold_q - 1'b1;
                        // Interlocks abort the minimum open time even with no request present.
                        if (sensor | bloqueio) begin
                            state_d = ERRO;
                            cod_d   = cod_falha;
                            deb_d   = DEB_CARGA;
                        end else if (!mesmo && hold_q == '0) begin
                            state_d = OCIOSO;
                        end
                    end
                    ERRO: begin
                        if (limpa_erro && !req) begin
                            state_d = OCIOSO;
                        end
`ifdef ERRO_AUTOLIMPA_EN
                        else if (req) begin
                            deb_d = DEB_CARGA;
                        end else if (deb_q == '0) begin
                            state_d = OCIOSO;
                        end else begin
                            deb_d = deb_q - 1'b1;
                        end
`endif
                    end
                    default: state_d = OCIOSO;
                endcase
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state_q <= OCIOSO;
                    deb_q   <= '0;
                    hold_q  <= '0;
                    modo_q  <= 1'b0;
                    cod_q   <= '0;
                end else begin
                    state_q <= state_d;
                    deb_q   <= deb_d;
                    hold_q  <= hold_d;
                    modo_q  <= modo_d;
                    cod_q   <= cod_d;
                end
            end

            assign rega[2*z+1]        = (state_q == REGANDO_ASP);
            assign rega[2*z]          = (state_q == REGANDO_GOT);
            assign erro_zona[z]       = (state_q == ERRO);
            assign erro_cod[2*z+1 -: 2] = (state_q == ERRO) ? cod_q : 2'b00;
        end
    endgenerate

    assign erro = |erro_zona;

endmodule

// File: tb/tb_valida_rega_multi.sv
// Bench for valida_rega_multi: reset-per-row vector table, directed multi-cycle sequences,
// and randomized stimulus against a count-up behavioural model of the zone rules.
module tb_valida_rega_multi;

    localparam int Z = 4;
    localparam int D = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] asp, got;
    logic [1:0] mef1;
    logic       limpeza, ve, limpa_erro;
    logic [7:0] rega;
    logic [3:0] erro_zona;
    logic [7:0] erro_cod;
    logic       erro;

    int checks = 0;
    int errors = 0;

    // Model: per-zone open mode (0 none, 1 sprinkler, 2 drip), pending mode, error flag/code,
    // and a count-up of edges spent in the current pending/open phase.
    int m_err [Z];
    int m_cod [Z];
    int m_open[Z];
    int m_pend[Z];
    int m_cnt [Z];

    typedef struct {
        logic [3:0] asp;
        logic [3:0] got;
        logic [1:0] mef1;
        logic       ve;
        logic       limp;
        logic [3:0] e_ez;
        logic [7:0] e_cod;
    } vec_t;
    vec_t tab[10];

    valida_rega_multi #(.ZONAS(Z), .DEB_CICLOS(D), .TEMPO_MIN(T)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .asp        (asp),
        .got        (got),
        .mef1       (mef1),
        .limpeza    (limpeza),
        .ve         (ve),
        .limpa_erro (limpa_erro),
        .rega       (rega),
        .erro_zona  (erro_zona),
        .erro_cod   (erro_cod),
        .erro       (erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < Z; z++) begin
            m_err[z] = 0; m_cod[z] = 0; m_open[z] = 0; m_pend[z] = 0; m_cnt[z] = 0;
        end
    endtask

    task automatic model_step();
        for (int z = 0; z < Z; z++) begin
            bit a, g, req, both, blk;
            int want, code;
            a    = asp[z];
            g    = got[z];
            req  = a | g;
            both = a & g;
            blk  = ve | limpeza | (mef1 != 2'b11);
            want = (a && !g) ? 1 : ((g && !a) ? 2 : 0);
            code = both ? 1 : (ve ? 2 : (limpeza ? 3 : 0));
            if (m_err[z] != 0) begin
                if (limpa_erro && !req) m_err[z] = 0;
            end else if (m_open[z] != 0) begin
                m_cnt[z]++;
                if (both || blk) begin
                    m_err[z] = 1; m_cod[z] = code; m_open[z] = 0;
                end else if (want != m_open[z] && m_cnt[z] >= T) begin
                    m_open[z] = 0;
                end
            end else if (m_pend[z] != 0) begin
                m_cnt[z]++;
                if (both || (req && blk)) begin
                    m_err[z] = 1; m_cod[z] = code; m_pend[z] = 0;
                end else if (want != m_pend[z]) begin
                    m_pend[z] = 0;
                end else if (m_cnt[z] >= D) begin
                    m_open[z] = m_pend[z]; m_pend[z] = 0; m_cnt[z] = 0;
                end
            end else begin
                if (both || (req && blk)) begin
                    m_err[z] = 1; m_cod[z] = code;
                end else if (want != 0) begin
                    m_pend[z] = want; m_cnt[z] = 0;
                end
            end
        end
    endtask

    task automatic model_check();
        logic [7:0] er, ec;
        logic [3:0] ez;
        er = '0; ec = '0; ez = '0;
        for (int z = 0; z < Z; z++) begin
            if (m_open[z] == 1) er[2*z+1] = 1'b1;
            if (m_open[z] == 2) er[2*z]   = 1'b1;
            if (m_err[z] != 0) begin
                ez[z] = 1'b1;
                ec[2*z +: 2] = 2'(m_cod[z]);
            end
        end
        chk("model_rega", rega, er);
        chk("model_erro_zona", erro_zona, ez);
        chk("model_erro_cod", erro_cod, ec);
        chk("model_erro", erro, |ez);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        asp = '0; got = '0; mef1 = 2'b11; ve = 1'b0; limpeza = 1'b0; limpa_erro = 1'b0;
        model_reset();
        #2;
        chk("reset_rega", rega, 8'h00);
        chk("reset_erro", erro, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] g, input logic [1:0] m,
                                input logic v, input logic l, input logic [3:0] ez, input logic [7:0] c);
        vec_t r;
        r.asp = a; r.got = g; r.mef1 = m; r.ve = v; r.limp = l; r.e_ez = ez; r.e_cod = c;
        return r;
    endfunction

    initial begin
        reset_n = 1'b0;
        asp = '0; got = '0; mef1 = 2'b11; ve = 1'b0; limpeza = 1'b0; limpa_erro = 1'b0;
        model_reset();

        // One edge after reset per row: error flags and codes, priority SENSOR > VE > LIMPEZA > ESTADO.
        tab[0] = mk(4'b0001, 4'b0000, 2'b01, 1'b0, 1'b0, 4'b0001, 8'h00);
        tab[1] = mk(4'b0001, 4'b0000, 2'b01, 1'b0, 1'b1, 4'b0001, 8'h03);
        tab[2] = mk(4'b0001, 4'b0000, 2'b11, 1'b1, 1'b1, 4'b0001, 8'h02);
        tab[3] = mk(4'b0001, 4'b0001, 2'b11, 1'b1, 1'b0, 4'b0001, 8'h01);
        tab[4] = mk(4'b0000, 4'b0001, 2'b00, 1'b0, 1'b1, 4'b0001, 8'h03);
        tab[5] = mk(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 4'b0000, 8'h00);
        tab[6] = mk(4'b0001, 4'b0000, 2'b11, 1'b0, 1'b0, 4'b0000, 8'h00);
        tab[7] = mk(4'b0000, 4'b0100, 2'b11, 1'b1, 1'b0, 4'b0100, 8'h20);
        tab[8] = mk(4'b1000, 4'b1000, 2'b11, 1'b0, 1'b0, 4'b1000, 8'h40);
        tab[9] = mk(4'b0011, 4'b0000, 2'b10, 1'b0, 1'b0, 4'b0011, 8'h00);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            asp = tab[i].asp; got = tab[i].got; mef1 = tab[i].mef1;
            ve = tab[i].ve; limpeza = tab[i].limp;
            tick();
            chk("tab_rega", rega, 8'h00);
            chk("tab_erro_zona", erro_zona, tab[i].e_ez);
            chk("tab_erro_cod", erro_cod, tab[i].e_cod);
            chk("tab_erro", erro, |tab[i].e_ez);
        end

        // Debounce latency and minimum open time with early request drop.
        do_reset();
        asp = 4'b0001;
        for (int e = 1; e <= 22; e++) begin
            tick();
            chk("s1_rega", rega, (e >= 5 && e <= 20) ? 8'h02 : 8'h00);
            if (e == 5) asp = 4'b0000;
        end
        chk("s1_erro", erro, 1'b0);

        // Short drip glitch never opens the valve.
        do_reset();
        got = 4'b0100;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 2) got = 4'b0000;
            chk("s2_rega", rega, 8'h00);
            chk("s2_erro", erro, 1'b0);
        end

        // Inlet valve while drip open, clear ignored while request high, then accepted.
        do_reset();
        got = 4'b0010;
        for (int e = 1; e <= 6; e++) tick();
        chk("s3_open", rega, 8'h04);
        ve = 1'b1;
        tick();
        ve = 1'b0;
        chk("s3_rega", rega, 8'h00);
        chk("s3_ez", erro_zona, 4'b0010);
        chk("s3_cod", erro_cod, 8'h08);
        chk("s3_erro", erro, 1'b1);
        limpa_erro = 1'b1;
        tick();
        limpa_erro = 1'b0;
        chk("s3_ignored_clear", erro_zona, 4'b0010);
        got = 4'b0000;
        tick();
        chk("s3_still_err", erro_zona, 4'b0010);
        limpa_erro = 1'b1;
        tick();
        limpa_erro = 1'b0;
        chk("s3_cleared", erro_zona, 4'b0000);
        chk("s3_erro_clr", erro, 1'b0);

        // Sensor fault in zone 3 alongside a normal opening in zone 0.
        do_reset();
        asp = 4'b1001; got = 4'b1000;
        tick();
        chk("s4_cod", erro_cod, 8'h40);
        chk("s4_ez", erro_zona, 4'b1000);
        asp = 4'b0001; got = 4'b0000;
        for (int e = 2; e <= 5; e++) tick();
        chk("s4_rega", rega, 8'h02);
        chk("s4_ez_hold", erro_zona, 4'b1000);

        // Asynchronous reset mid-cycle with two valves open and one zone in error.
        do_reset();
        asp = 4'b0111; got = 4'b0010;
        for (int e = 1; e <= 5; e++) tick();
        chk("s6_rega_open", rega, 8'h22);
        chk("s6_erro_set", erro, 1'b1);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("s6_async_rega", rega, 8'h00);
        chk("s6_async_erro", erro, 1'b0);
        chk("s6_async_ez", erro_zona, 4'b0000);
        chk("s6_async_cod", erro_cod, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized run against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] a, g;
            a = asp; g = got;
            for (int z = 0; z < Z; z++) begin
                if ($urandom_range(0, 15) == 0) a[z] = ~a[z];
                if ($urandom_range(0, 23) == 0) g[z] = ~g[z];
            end
            asp = a; got = g;
            ve = ($urandom_range(0, 63) == 0);
            limpeza = ($urandom_range(0, 95) == 0);
            mef1 = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            limpa_erro = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
